// File: rtl/oam_dma_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dma_pkg
//  Brief    : Shared types, address constants and helpers for the OAM DMA
//             controller.
//  Revision : 1.0 - initial release
// ============================================================================
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;
    localparam logic [7:0]  ECHO_BASE    = 8'hE0;

    // Source pages at or above the echo region fold back onto work RAM.
    function automatic logic [15:0] dma_src_addr(input logic [7:0] src_hi,
                                                 input logic [7:0] idx);
        logic [7:0] w_hi;
        w_hi = (src_hi >= ECHO_BASE) ? (src_hi - 8'h20) : src_hi;
        return {w_hi, idx};
    endfunction

    function automatic logic is_hram(input logic [15:0] addr);
        return (addr >= HRAM_LO) && (addr <= HRAM_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : oam_dma_controller_if
//  Brief    : CPU-side, system-bus-side and OAM-port signals of the OAM DMA
//             controller. The controller takes the slave view; the CPU, bus
//             and PPU environment takes the master view.
//  Revision : 1.0 - initial release
// ============================================================================
interface oam_dma_controller_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        dma_active;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_rdata,
        output cpu_rdata, cpu_wait, bus_req, bus_we, bus_addr, bus_wdata,
               oam_we, oam_addr, oam_wdata, dma_active
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_rdata,
        input  cpu_rdata, cpu_wait, bus_req, bus_we, bus_addr, bus_wdata,
               oam_we, oam_addr, oam_wdata, dma_active
    );
endinterface
`default_nettype wire

// File: rtl/oam_dma_controller_cpu_bus_gate.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_gate
//  Brief    : Combinational CPU access filter. Decides whether a CPU access
//             reaches the system bus, must stall, or is blocked, and selects
//             the CPU read data.
//  Config   : OAM_DMA_BUS_CONFLICT_EN - blocked reads during XFER return the
//             last byte fetched by the DMA engine instead of 8'hFF.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_gate
    import dma_pkg::*;
(
    input  wire dma_state_t  i_state,
    input  wire logic        i_slot0,
    input  wire logic [7:0]  i_data_q,
    input  wire logic [7:0]  i_src_hi,
    input  wire logic        i_cpu_req,
    input  wire logic        i_cpu_we,
    input  wire logic [15:0] i_cpu_addr,
    input  wire logic [7:0]  i_bus_rdata,
    output logic             o_fwd,
    output logic             o_wait,
    output logic             o_reg_wr,
    output logic [7:0]       o_rdata
);

`ifdef OAM_DMA_BUS_CONFLICT_EN
    localparam logic c_CONFLICT = 1'b1;
`else
    localparam logic c_CONFLICT = 1'b0;
`endif

    logic w_is_reg;
    logic w_is_hram;

    // Classify the CPU access and route it: register, pass-through, stall or block.
    always_comb begin
        w_is_reg  = (i_cpu_addr == DMA_REG_ADDR);
        w_is_hram = is_hram(i_cpu_addr);
        o_reg_wr  = i_cpu_req & i_cpu_we & w_is_reg;
        o_fwd     = 1'b0;
        o_wait    = 1'b0;
        o_rdata   = 8'hFF;
        if (w_is_reg) begin
            // The DMA source register is local and never reaches the bus.
            o_rdata = i_src_hi;
        end else if (i_state == IDLE) begin
            o_fwd   = i_cpu_req;
            o_rdata = i_bus_rdata;
        end else if (w_is_hram) begin
            // HRAM stays reachable except on the cycle the DMA owns the bus.
            o_rdata = i_bus_rdata;
            if (i_slot0) begin
                o_wait = i_cpu_req;
            end else begin
                o_fwd  = i_cpu_req;
            end
        end else if (c_CONFLICT && (i_state == XFER)) begin
            o_rdata = i_data_q;
        end
    end

endmodule
`default_nettype wire

// File: rtl/oam_dma_controller.sv
`default_nettype none
// ============================================================================
//  Module   : oam_dma_controller
//  Brief    : OAM DMA sequencer. A CPU write to FF46 copies DMA_LEN bytes from
//             {FF46,8'h00} into OAM while arbitrating the shared system bus
//             between the CPU and the DMA engine.
//  Config   : OAM_DMA_BUS_CONFLICT_EN - bus-conflict read data (see
//             cpu_bus_gate).
//  Revision : 1.0 - initial release
// ============================================================================
module oam_dma_controller
    import dma_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int START_DELAY     = 4,
    parameter int DMA_LEN         = 160
)
(
    input  wire logic             clk,
    input  wire logic             reset,
    oam_dma_controller_if.slave   dma_if
);

    localparam int c_CNT_MAX = (START_DELAY > CYCLES_PER_BYTE) ? START_DELAY : CYCLES_PER_BYTE;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(START_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_SLOT_LAST  = c_CNT_W'(CYCLES_PER_BYTE - 1);
    localparam logic [c_CNT_W-1:0] c_SLOT_PRE   = c_CNT_W'(CYCLES_PER_BYTE - 2);
    localparam logic [c_CNT_W-1:0] c_CAPTURE    = c_CNT_W'(1);
    localparam logic [7:0]         c_IDX_LAST   = 8'(DMA_LEN - 1);

    dma_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_idx;
    logic [7:0]         r_src_hi;
    logic [7:0]         r_data_q;
    logic               r_oam_we;
    logic [7:0]         r_oam_addr;
    logic               r_active;

    logic               w_slot0;
    logic [15:0]        w_src_addr;
    logic               w_fwd;
    logic               w_wait;
    logic               w_reg_wr;
    logic [7:0]         w_cpu_rdata;
    logic [7:0]         w_oam_wdata;

    assign w_slot0    = (r_state == XFER) && (r_cnt == '0);
    assign w_src_addr = dma_src_addr(r_src_hi, r_idx);

    cpu_bus_gate u_gate (
        .i_state     (r_state),
        .i_slot0     (w_slot0),
        .i_data_q    (r_data_q),
        .i_src_hi    (r_src_hi),
        .i_cpu_req   (dma_if.cpu_req),
        .i_cpu_we    (dma_if.cpu_we),
        .i_cpu_addr  (dma_if.cpu_addr),
        .i_bus_rdata (dma_if.bus_rdata),
        .o_fwd       (w_fwd),
        .o_wait      (w_wait),
        .o_reg_wr    (w_reg_wr),
        .o_rdata     (w_cpu_rdata)
    );

    // With two-cycle slots the byte arrives on the write cycle itself, so it
    // must bypass the capture register.
    generate
        if (CYCLES_PER_BYTE == 2) begin : g_wdata_bypass
            assign w_oam_wdata = dma_if.bus_rdata;
        end else begin : g_wdata_latched
            assign w_oam_wdata = r_data_q;
        end
    endgenerate

    // Transfer sequencer: START delay, per-byte slots, and FF46 (re)start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= 8'h00;
            r_src_hi   <= 8'hFF;
            r_data_q   <= 8'h00;
            r_oam_we   <= 1'b0;
            r_oam_addr <= 8'h00;
            r_active   <= 1'b0;
        end else begin
            r_oam_we <= 1'b0;
            case (r_state)
                START: begin
                    if (r_cnt == c_START_LAST) begin
                        r_state <= XFER;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (r_cnt == c_CAPTURE) begin
                        r_data_q <= dma_if.bus_rdata;
                    end
                    // Arm the OAM strobe so it is registered on the slot's last cycle.
                    if (r_cnt == c_SLOT_PRE) begin
                        r_oam_we   <= 1'b1;
                        r_oam_addr <= r_idx;
                    end
                    if (r_cnt == c_SLOT_LAST) begin
                        r_cnt <= '0;
                        if (r_idx == c_IDX_LAST) begin
                            r_state  <= IDLE;
                            r_active <= 1'b0;
                            r_idx    <= 8'h00;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            // A register write restarts from scratch in any state; a DMA read
            // already on the bus this cycle still completes.
            if (w_reg_wr) begin
                r_src_hi <= dma_if.cpu_wdata;
                r_state  <= START;
                r_cnt    <= '0;
                r_idx    <= 8'h00;
                r_active <= 1'b1;
                r_oam_we <= 1'b0;
            end
        end
    end

    assign dma_if.bus_req    = w_slot0 | w_fwd;
    assign dma_if.bus_we     = w_fwd & dma_if.cpu_we;
    assign dma_if.bus_addr   = w_slot0 ? w_src_addr : dma_if.cpu_addr;
    assign dma_if.bus_wdata  = dma_if.cpu_wdata;
    assign dma_if.cpu_rdata  = w_cpu_rdata;
    assign dma_if.cpu_wait   = w_wait;
    assign dma_if.oam_we     = r_oam_we;
    assign dma_if.oam_addr   = r_oam_addr;
    assign dma_if.oam_wdata  = w_oam_wdata;
    assign dma_if.dma_active = r_active;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oam_dma_controller
//  Brief    : Scoreboard bench for oam_dma_controller with a flat memory
//             model on the system bus and a transfer-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_oam_dma_controller;

    localparam int CPB = 4;
    localparam int SD  = 4;
    localparam int LEN = 160;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    oam_dma_controller_if dut_if ();

    oam_dma_controller #(
        .CYCLES_PER_BYTE (CPB),
        .START_DELAY     (SD),
        .DMA_LEN         (LEN)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .dma_if (dut_if)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] rd_q  [$];
    logic [15:0] oam_q [$];

    // Flat 64 KiB memory on the system bus; read data appears the next cycle.
    logic [7:0] mem [0:65535];
    logic [7:0] rd_data_r = 8'h00;
    logic       mem_ready = 1'b0;
    assign dut_if.bus_rdata = rd_data_r;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 65536; a++) begin
                if (a >= 32'hC000 && a < 32'hC0A0) mem[a] <= 8'(a[7:0] ^ 8'h5A);
                else                               mem[a] <= 8'($urandom);
            end
            mem_ready <= 1'b1;
        end else if (dut_if.bus_req) begin
            if (dut_if.bus_we) mem[dut_if.bus_addr] <= dut_if.bus_wdata;
            else               rd_data_r <= mem[dut_if.bus_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference source address: echo pages fold back by 0x2000.
    function automatic logic [15:0] src_of(input logic [7:0] hi, input int i);
        int page;
        page = (hi >= 8'hE0) ? (int'(hi) - 32) : int'(hi);
        return 16'(page * 256 + i);
    endfunction

    task automatic push_transfer(input logic [7:0] hi);
        for (int i = 0; i < LEN; i++) begin
            rd_q.push_back(src_of(hi, i));
            oam_q.push_back({8'(i), mem[src_of(hi, i)]});
        end
    endtask

    task automatic flush();
        rd_q.delete();
        oam_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic req, input logic we, input logic [15:0] a, input logic [7:0] d);
        dut_if.cpu_req   = req;
        dut_if.cpu_we    = we;
        dut_if.cpu_addr  = a;
        dut_if.cpu_wdata = d;
    endtask

    task automatic wait_oam(input int idx);
        bit seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            if (dut_if.oam_we && dut_if.oam_addr == 8'(idx)) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL wait_oam: oam write %0d never seen, expected within 4000 cycles", idx);
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (!dut_if.dma_active) done = 1'b1;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL wait_idle: dma_active still 1, expected 0 within 4000 cycles");
        end
    endtask

    // Issue an FF46 write from IDLE and load the expected transfer.
    task automatic start_dma(input logic [7:0] hi);
        tick();
        cpu(1'b1, 1'b1, 16'hFF46, hi);
        flush();
        push_transfer(hi);
        @(negedge clk);
        check("ff46_not_forwarded", 32'(dut_if.bus_req), 32'd0);
        tick();
        cpu(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    // Monitor: pops the scoreboard on every OAM write and every DMA source read.
    always @(negedge clk) begin
        if (reset) begin
            if (dut_if.oam_we) begin
                if (oam_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL oam_write: got unexpected write addr=%0h data=%0h, expected none",
                             dut_if.oam_addr, dut_if.oam_wdata);
                end else begin
                    check("oam_write", {16'h0, dut_if.oam_addr, dut_if.oam_wdata}, {16'h0, oam_q.pop_front()});
                end
            end
            if (dut_if.bus_req && dut_if.dma_active && dut_if.bus_addr < 16'hFF80) begin
                if (dut_if.bus_we) begin
                    n_vec++; n_err++;
                    $display("FAIL bus_write_blocked: got bus write to %0h during DMA, expected none",
                             dut_if.bus_addr);
                end else if (rd_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL dma_read: got unexpected read of %0h, expected none", dut_if.bus_addr);
                end else begin
                    check("dma_read_addr", 32'(dut_if.bus_addr), 32'(rd_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_b;
        logic [7:0] rhi;
        int         active_cycles;

        cpu(1'b0, 1'b0, 16'h0000, 8'h00);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset_outputs", {dut_if.dma_active, dut_if.oam_we, dut_if.cpu_wait, dut_if.bus_req},
              4'b0000);
        check("reset_oam_addr", 32'(dut_if.oam_addr), 32'h0);
        tick();
        cpu(1'b1, 1'b0, 16'hFF46, 8'h00);
        @(negedge clk);
        check("reset_ff46_read", {dut_if.bus_req, dut_if.cpu_rdata}, {1'b0, 8'hFF});

        // IDLE pass-through read and write
        tick();
        cpu(1'b1, 1'b0, 16'h1234, 8'h00);
        exp_b = mem[16'h1234];
        @(negedge clk);
        check("idle_read_fwd", {dut_if.bus_req, dut_if.bus_we, dut_if.bus_addr}, {2'b10, 16'h1234});
        tick();
        cpu(1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        check("idle_read_data", 32'(dut_if.cpu_rdata), 32'(exp_b));
        tick();
        cpu(1'b1, 1'b1, 16'h2000, 8'hA5);
        @(negedge clk);
        check("idle_write_fwd", {dut_if.bus_req, dut_if.bus_we, dut_if.bus_addr, dut_if.bus_wdata},
              {2'b11, 16'h2000, 8'hA5});
        tick();
        cpu(1'b0, 1'b0, 16'h0000, 8'h00);

        // Full transfer from C000 and dma_active duration
        start_dma(8'hC0);
        active_cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (dut_if.dma_active) active_cycles++;
            else break;
        end
        check("active_cycles", 32'(active_cycles), 32'(SD + LEN * CPB));
        check("xfer1_drained", 32'(rd_q.size() + oam_q.size()), 32'd0);

        // Echo source E1 -> C1xx, blocked CPU traffic, HRAM stall, restart
        start_dma(8'hE1);
        wait_oam(10);
        tick();
        cpu(1'b1, 1'b0, 16'h8000, 8'h00);
        @(negedge clk);
`ifdef OAM_DMA_BUS_CONFLICT_EN
        check("blocked_read", 32'(dut_if.cpu_rdata), 32'(mem[src_of(8'hE1, 10)]));
`else
        check("blocked_read", 32'(dut_if.cpu_rdata), 32'hFF);
`endif
        tick();
        cpu(1'b1, 1'b1, 16'h8000, 8'h55);
        @(negedge clk);
        check("blocked_write_no_req", 32'(dut_if.bus_req), 32'd0);
        tick();
        cpu(1'b1, 1'b0, 16'hFF46, 8'h00);
        @(negedge clk);
        check("ff46_read_busy", 32'(dut_if.cpu_rdata), 32'hE1);
        tick();
        cpu(1'b0, 1'b0, 16'h0000, 8'h00);

        wait_oam(20);
        tick();
        cpu(1'b1, 1'b1, 16'hFF90, 8'h3C);
        @(negedge clk);
        check("hram_slot0_wait", {dut_if.cpu_wait, dut_if.bus_we}, 2'b10);
        tick();
        @(negedge clk);
        check("hram_next_cycle", {dut_if.cpu_wait, dut_if.bus_req, dut_if.bus_we, dut_if.bus_addr,
              dut_if.bus_wdata}, {3'b011, 16'hFF90, 8'h3C});
        tick();
        cpu(1'b0, 1'b0, 16'h0000, 8'h00);

        wait_oam(79);
        tick();
        cpu(1'b1, 1'b1, 16'hFF46, 8'hD0);
        flush();
        rd_q.push_back(src_of(8'hE1, 80));
        push_transfer(8'hD0);
        tick();
        cpu(1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        check("restart_start", {dut_if.dma_active, dut_if.oam_we, dut_if.bus_req}, 3'b100);
        wait_idle();
        check("restart_drained", 32'(rd_q.size() + oam_q.size()), 32'd0);

        // Reset in the middle of a transfer
        rhi = 8'($urandom);
        start_dma(rhi);
        wait_oam(50);
        tick();
        reset = 1'b0;
        flush();
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("midreset_idle", {dut_if.dma_active, dut_if.oam_we}, 2'b00);
        tick();
        cpu(1'b1, 1'b0, 16'hFF46, 8'h00);
        @(negedge clk);
        check("midreset_ff46", {dut_if.bus_req, dut_if.cpu_rdata}, {1'b0, 8'hFF});
        tick();
        cpu(1'b1, 1'b0, 16'h8000, 8'h00);
        @(negedge clk);
        check("midreset_bus_back", {dut_if.cpu_wait, dut_if.bus_req, dut_if.bus_addr}, {2'b01, 16'h8000});
        tick();
        cpu(1'b0, 1'b0, 16'h0000, 8'h00);

        // Randomized source pages
        for (int t = 0; t < 3; t++) begin
            repeat ($urandom_range(1, 20)) tick();
            rhi = 8'($urandom);
            start_dma(rhi);
            wait_idle();
            check("rand_drained", 32'(rd_q.size() + oam_q.size()), 32'd0);
        end

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
